bath_agent: RTL and testbench
=============================

# bath_agent

Vessel-side transit sequencer for the airlock: the initiator on the other end of the lock controller's arrival/departure interface. On command it raises the arriving or leaving request toward the lock controller and follows the controller's door responses through the two-door transit. It flags any interlock violation it detects. It sits beside the lock controller on the board top level, replacing the manual bath arriving/leaving switches for scripted transits.

## Interface

- DWELL, 4: cycles the vessel spends passing through an open door (1..65535).
- TIMEOUT, 1000: maximum cycles any wait state may last before fault (1..65535; used only with BATH_TIMEOUT_EN).
- clk, input, 1: the single clock; everything is on its rising edge.
- reset, input, 1: asynchronous, active-low reset.
- go, input, 1: level; start a transit when sampled high in IDLE.
- dir, input, 1: 0 = arrive (outer door is the near door, inner door is the far door); 1 = leave (inner door is near, outer door is far). Latched when go is accepted.
- abort, input, 1: returns the block to IDLE from any state.
- outer_door, input, 1: 1 = outer door open (lock controller output).
- inner_door, input, 1: 1 = inner door open.
- arriving, output, 1: arrival request to the lock controller.
- leaving, output, 1: departure request to the lock controller.
- in_lock, output, 1: vessel is inside the chamber.
- busy, output, 1: high in every state except IDLE.
- done, output, 1: one-cycle pulse when a transit completes.
- fault, output, 1: high while in FAULT.
- state, output, 3: current state encoding, for the display.

## Operation

- States and encodings: IDLE 0, REQUEST 1, ENTER 2, SEAL 3, WAIT_FAR 4, EXIT 5, CLEAR 6, FAULT 7.
- IDLE → REQUEST when go=1; dir_q <= dir.
- REQUEST → ENTER when the near door opens.
- ENTER: the dwell counter counts DWELL cycles. At count DWELL-1 → SEAL and in_lock <= 1. If the near door closes before that → FAULT.
- SEAL → WAIT_FAR when the near door closes.
- WAIT_FAR → EXIT when the far door opens.
- EXIT: the dwell counter counts DWELL cycles, then → CLEAR and in_lock <= 0. If the far door closes early → FAULT.
- CLEAR → DONE action when the far door closes: done=1 for that one cycle and state → IDLE. If go is still high, the next transit is accepted from IDLE on the following cycle.
- Request outputs: arriving = busy & ~dir_q & ~fault. leaving = busy & dir_q & ~fault. They are held from REQUEST through CLEAR.
- Interlock violation: outer_door & inner_door in any state other than IDLE/FAULT → FAULT next cycle.
- FAULT is sticky. It exits only on abort or reset. in_lock holds its value in FAULT.
- Priority when events coincide, highest first: reset, abort, violation, timeout, normal transition.
- abort → IDLE next cycle, with in_lock <= 0 and no done pulse.

## Timing

- Reset values: state=IDLE, arriving=0, leaving=0, in_lock=0, busy=0, done=0, fault=0. Both counters are 0.
- All outputs are registered or decoded from registered state only. There are no combinational input-to-output paths.
- go → arriving/leaving high: 1 cycle.
- Door edge → state change: 1 cycle.
- Near door open → in_lock=1: DWELL+1 cycles.
- Counters are 16-bit unsigned and clear on every state change. Counters never wrap: each terminal compare happens before overflow.
- A door input that changes in the same cycle as a terminal count is ignored; the terminal count wins, except for a violation, which always wins.
- Reset asserted mid-transit clears everything immediately, without waiting for a clock edge.

## Configuration

- BATH_TIMEOUT_EN defined:
  - A 16-bit wait counter runs in REQUEST, SEAL, WAIT_FAR and CLEAR.
  - Reaching TIMEOUT-1 moves the block to FAULT on the next edge.
- BATH_TIMEOUT_EN undefined:
  - The wait counter and the timeout fault are absent.
  - Wait states wait indefinitely.
  - DWELL behaviour and violation detection are unchanged.

## Test plan

Benches use DWELL=4 and TIMEOUT=20.

- Arrive: go=1, dir=0 → arriving=1 next cycle. Open outer → in_lock=1 5 cycles later. Close outer, open inner, wait 4 cycles, close inner → done pulses once, state=0, arriving=0.
- Leave: same door sequence with dir=1, inner door first → leaving=1 throughout, arriving stays 0, done pulses once.
- Early close: outer opens in ENTER and closes after 2 cycles → state=7, fault=1, requests drop. abort=1 → state=0 next cycle, in_lock=0.
- Violation: during WAIT_FAR, drive outer=1 and inner=1 together → fault=1 next cycle. The fault holds while both doors then close.
- Timeout (BATH_TIMEOUT_EN): go=1 with no door activity → state=7 exactly 20 cycles after entering REQUEST. Without the macro, the block is still in state 1 after 100 cycles.
- Reset mid-transit: reset=0 asynchronously while in EXIT → all outputs 0 immediately, with no done pulse.

Source files
------------

// File: rtl/bath_agent.sv
// Vessel-side airlock transit sequencer: requests arrival/departure and tracks the two-door passage.
// Optional wait-state timeout fault is enabled by defining BATH_TIMEOUT_EN.
module bath_agent #(
    parameter int DWELL   = 4,
    parameter int TIMEOUT = 1000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_go,
    input  logic       i_dir,
    input  logic       i_abort,
    input  logic       i_outer_door,
    input  logic       i_inner_door,
    output logic       o_arriving,
    output logic       o_leaving,
    output logic       o_in_lock,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_fault,
    output logic [2:0] o_state
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        REQUEST  = 3'd1,
        ENTER    = 3'd2,
        SEAL     = 3'd3,
        WAIT_FAR = 3'd4,
        EXIT     = 3'd5,
        CLEAR    = 3'd6,
        FAULT    = 3'd7
    } state_t;

    localparam logic [15:0] LP_DWELL_LAST = 16'(DWELL - 1);

    state_t      r_state;
    state_t      w_next;
    logic        r_dir_q;
    logic        r_in_lock;
    logic        r_done;
    logic [15:0] r_dwell_cnt;
    logic        w_near;
    logic        w_far;
    logic        w_violation;
    logic        w_timeout;
    logic        w_dwell_last;
    logic        w_complete;

    // Arriving vessels meet the outer door first; leaving vessels meet the inner door first.
    assign w_near       = r_dir_q ? i_inner_door : i_outer_door;
    assign w_far        = r_dir_q ? i_outer_door : i_inner_door;
    assign w_violation  = i_outer_door & i_inner_door & (r_state != IDLE) & (r_state != FAULT);
    assign w_dwell_last = (r_dwell_cnt == LP_DWELL_LAST);

`ifdef BATH_TIMEOUT_EN
    localparam logic [15:0] LP_TIMEOUT_LAST = 16'(TIMEOUT - 1);

    logic [15:0] r_wait_cnt;
    logic        w_wait_state;

    assign w_wait_state = (r_state == REQUEST) | (r_state == SEAL) |
                          (r_state == WAIT_FAR) | (r_state == CLEAR);
    assign w_timeout    = w_wait_state & (r_wait_cnt == LP_TIMEOUT_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wait_cnt <= 16'd0;
        end else if (w_next != r_state) begin
            r_wait_cnt <= 16'd0;
        end else if (w_wait_state) begin
            r_wait_cnt <= r_wait_cnt + 16'd1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_dir_q     <= 1'b0;
            r_in_lock   <= 1'b0;
            r_done      <= 1'b0;
            r_dwell_cnt <= 16'd0;
        end else begin
            r_state <= w_next;
            r_done  <= w_complete;
            if ((r_state == IDLE) && (w_next == REQUEST)) begin
                r_dir_q <= i_dir;
            end
            if (w_next == IDLE) begin
                r_in_lock <= 1'b0;
            end else if ((r_state == ENTER) && (w_next == SEAL)) begin
                r_in_lock <= 1'b1;
            end else if ((r_state == EXIT) && (w_next == CLEAR)) begin
                r_in_lock <= 1'b0;
            end
            if (w_next != r_state) begin
                r_dwell_cnt <= 16'd0;
            end else if ((r_state == ENTER) || (r_state == EXIT)) begin
                r_dwell_cnt <= r_dwell_cnt + 16'd1;
            end
        end
    end

    // Abort beats violation beats timeout beats the door-driven sequence; terminal dwell beats door edges.
    always_comb begin
        w_next     = r_state;
        w_complete = 1'b0;
        if (i_abort) begin
            w_next = IDLE;
        end else if (w_violation || w_timeout) begin
            w_next = FAULT;
        end else begin
            case (r_state)
                IDLE:     if (i_go) w_next = REQUEST;
                REQUEST:  if (w_near) w_next = ENTER;
                ENTER: begin
                    if (w_dwell_last) w_next = SEAL;
                    else if (!w_near) w_next = FAULT;
                end
                SEAL:     if (!w_near) w_next = WAIT_FAR;
                WAIT_FAR: if (w_far) w_next = EXIT;
                EXIT: begin
                    if (w_dwell_last) w_next = CLEAR;
                    else if (!w_far) w_next = FAULT;
                end
                CLEAR: begin
                    if (!w_far) begin
                        w_next     = IDLE;
                        w_complete = 1'b1;
                    end
                end
                FAULT:    w_next = FAULT;
            endcase
        end
    end

    always_comb begin
        o_state    = r_state;
        o_busy     = (r_state != IDLE);
        o_fault    = (r_state == FAULT);
        o_arriving = o_busy & ~r_dir_q & ~o_fault;
        o_leaving  = o_busy & r_dir_q & ~o_fault;
        o_in_lock  = r_in_lock;
        o_done     = r_done;
    end

endmodule

// File: tb/tb_bath_agent.sv
// Directed table-driven bench for bath_agent with DWELL=4, TIMEOUT=20.
module tb_bath_agent;

   typedef struct {
      string    name;
      bit [4:0] stim;
      bit [2:0] expState;
      bit [5:0] expOuts;
   } vec_t;

   logic       clk;
   logic       rstN;
   logic       go, dir, abort, outerDoor, innerDoor;
   logic       arriving, leaving, inLock, busy, done, fault;
   logic [2:0] state;

   int   errors = 0;
   int   checks = 0;
   vec_t vecs[$];

   bath_agent #(.DWELL(4), .TIMEOUT(20)) dut (
      .i_clk(clk),
      .i_rst_n(rstN),
      .i_go(go),
      .i_dir(dir),
      .i_abort(abort),
      .i_outer_door(outerDoor),
      .i_inner_door(innerDoor),
      .o_arriving(arriving),
      .o_leaving(leaving),
      .o_in_lock(inLock),
      .o_busy(busy),
      .o_done(done),
      .o_fault(fault),
      .o_state(state)
   );

   // Free-running 10-unit clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stimulus {go,dir,abort,outer,inner} is driven on the falling edge; outputs are read 1 unit after the rising edge
   task automatic applyStimulus(input bit [4:0] stim);
      @(negedge clk);
      {go, dir, abort, outerDoor, innerDoor} = stim;
      @(posedge clk);
      #1;
   endtask

   // Outputs are grouped as {arriving,leaving,in_lock,busy,done,fault}
   task automatic checkOutput(input string name, input bit [2:0] expState, input bit [5:0] expOuts);
      bit [5:0] gotOuts;
      gotOuts = {arriving, leaving, inLock, busy, done, fault};
      checks++;
      if ((state !== expState) || (gotOuts !== expOuts)) begin
         errors++;
         $display("[TB] FAIL %s: got state=%0d outs=%b, expected state=%0d outs=%b",
                  name, state, gotOuts, expState, expOuts);
      end
   endtask

   task automatic addVec(input string name, input bit [4:0] stim, input bit [2:0] st, input bit [5:0] outs);
      vec_t v;
      v.name = name;
      v.stim = stim;
      v.expState = st;
      v.expOuts = outs;
      vecs.push_back(v);
   endtask

   // Main sequence: table of transits, then timeout and asynchronous reset corner cases
   initial begin
      rstN = 1'b0;
      {go, dir, abort, outerDoor, innerDoor} = 5'b00000;
      #2;
      checkOutput("reset_async", 3'd0, 6'b000000);
      @(negedge clk);
      @(negedge clk);
      checkOutput("reset_held", 3'd0, 6'b000000);
      rstN = 1'b1;

      addVec("arr_go",     5'b10000, 3'd1, 6'b100100);
      for (int i = 0; i < 4; i++) addVec("arr_enter", 5'b00010, 3'd2, 6'b100100);
      addVec("arr_seal",   5'b00010, 3'd3, 6'b101100);
      addVec("arr_wait",   5'b00000, 3'd4, 6'b101100);
      for (int i = 0; i < 4; i++) addVec("arr_exit", 5'b00001, 3'd5, 6'b101100);
      addVec("arr_clear",  5'b00001, 3'd6, 6'b100100);
      addVec("arr_done",   5'b00000, 3'd0, 6'b000010);
      addVec("arr_idle",   5'b00000, 3'd0, 6'b000000);

      addVec("lv_go",      5'b11000, 3'd1, 6'b010100);
      for (int i = 0; i < 4; i++) addVec("lv_enter", 5'b01001, 3'd2, 6'b010100);
      addVec("lv_seal",    5'b01001, 3'd3, 6'b011100);
      addVec("lv_wait",    5'b01000, 3'd4, 6'b011100);
      for (int i = 0; i < 4; i++) addVec("lv_exit", 5'b01010, 3'd5, 6'b011100);
      addVec("lv_clear",   5'b01010, 3'd6, 6'b010100);
      addVec("lv_done",    5'b11000, 3'd0, 6'b000010);
      addVec("lv_rego",    5'b11000, 3'd1, 6'b010100);
      addVec("lv_abort",   5'b00100, 3'd0, 6'b000000);

      addVec("ec_go",      5'b10000, 3'd1, 6'b100100);
      addVec("ec_enter0",  5'b00010, 3'd2, 6'b100100);
      addVec("ec_enter1",  5'b00010, 3'd2, 6'b100100);
      addVec("ec_fault",   5'b00000, 3'd7, 6'b000101);
      addVec("ec_sticky",  5'b00000, 3'd7, 6'b000101);
      addVec("ec_abort",   5'b00100, 3'd0, 6'b000000);

      addVec("tw_go",      5'b10000, 3'd1, 6'b100100);
      for (int i = 0; i < 4; i++) addVec("tw_enter", 5'b00010, 3'd2, 6'b100100);
      addVec("tw_seal",    5'b00000, 3'd3, 6'b101100);
      addVec("tw_wait",    5'b00000, 3'd4, 6'b101100);
      addVec("tw_abort",   5'b00100, 3'd0, 6'b000000);

      addVec("vi_go",      5'b10000, 3'd1, 6'b100100);
      for (int i = 0; i < 4; i++) addVec("vi_enter", 5'b00010, 3'd2, 6'b100100);
      addVec("vi_seal",    5'b00010, 3'd3, 6'b101100);
      addVec("vi_wait",    5'b00000, 3'd4, 6'b101100);
      addVec("vi_both",    5'b00011, 3'd7, 6'b001101);
      addVec("vi_hold",    5'b00000, 3'd7, 6'b001101);
      addVec("vi_abort",   5'b00100, 3'd0, 6'b000000);

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].stim);
         checkOutput(vecs[i].name, vecs[i].expState, vecs[i].expOuts);
      end

      applyStimulus(5'b10000);
      checkOutput("to_request", 3'd1, 6'b100100);
`ifdef BATH_TIMEOUT_EN
      for (int i = 0; i < 18; i++) applyStimulus(5'b00000);
      applyStimulus(5'b00000);
      checkOutput("to_before", 3'd1, 6'b100100);
      applyStimulus(5'b00000);
      checkOutput("to_fault", 3'd7, 6'b000101);
`else
      for (int i = 0; i < 100; i++) applyStimulus(5'b00000);
      checkOutput("to_absent", 3'd1, 6'b100100);
`endif
      applyStimulus(5'b00100);
      checkOutput("to_abort", 3'd0, 6'b000000);

      applyStimulus(5'b10000);
      for (int i = 0; i < 4; i++) applyStimulus(5'b00010);
      applyStimulus(5'b00010);
      applyStimulus(5'b00000);
      applyStimulus(5'b00001);
      applyStimulus(5'b00001);
      checkOutput("rst_in_exit", 3'd5, 6'b101100);
      #2;
      rstN = 1'b0;
      #1;
      checkOutput("rst_immediate", 3'd0, 6'b000000);
      @(negedge clk);
      rstN = 1'b1;
      applyStimulus(5'b00000);
      checkOutput("rst_no_done", 3'd0, 6'b000000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
